rob_commit_unit: RTL and testbench

- Reorder buffer for the out-of-order RISC-V core; the producing end of the register-file commit/rename interface.
- Allocates a tag per decoded instruction, which the register file records as the rd dependency.
- Captures results from the CDB and retires entries strictly in order, driving the commit value/tag that the register file consumes.
- Detects branch mispredictions at commit and issues the global flush.

---
 rtl/rob_commit_unit.sv | 205 ++++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates tags in program order, captures CDB results, and
// retires entries in order, raising a flush when a committed branch mispredicted.
module rob_commit_unit #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int REG_NUM_WIDTH  = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      dec_valid,
    input  logic [1:0]                dec_type,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic                      dec_pred_taken,
    input  logic [31:0]               dec_alt_pc,
    output logic [ROB_SIZE_WIDTH:0]   new_tag_out,
    output logic                      full_out,
    input  logic                      cdb_valid,
    input  logic [ROB_SIZE_WIDTH:0]   cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic                      cdb_taken,
    input  logic [ROB_SIZE_WIDTH:0]   q1_tag,
    input  logic [ROB_SIZE_WIDTH:0]   q2_tag,
    output logic                      q1_ready,
    output logic                      q2_ready,
    output logic [31:0]               q1_value,
    output logic [31:0]               q2_value,
    output logic                      commit_valid,
    output logic [REG_NUM_WIDTH-1:0]  commit_rd,
    output logic [31:0]               commit_value,
    output logic [ROB_SIZE_WIDTH:0]   commit_tag,
    output logic                      st_commit_out,
    output logic                      flush_out,
    output logic [31:0]               flush_pc_out
);

    localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] NO_TAG     = '1;
    localparam logic [ROB_SIZE_WIDTH:0] FULL_COUNT = (ROB_SIZE_WIDTH + 1)'(ROB_SIZE);
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    typedef enum logic [1:0] {
        ENTRY_EMPTY  = 2'd0,
        ENTRY_ISSUED = 2'd1,
        ENTRY_READY  = 2'd2
    } entry_state_t;

    entry_state_t state_q [ROB_SIZE];
    entry_state_t state_d [ROB_SIZE];

    logic [1:0]               type_q   [ROB_SIZE];
    logic [REG_NUM_WIDTH-1:0] rd_q     [ROB_SIZE];
    logic                     pred_q   [ROB_SIZE];
    logic [31:0]              alt_pc_q [ROB_SIZE];
    logic [31:0]              value_q  [ROB_SIZE];
    logic                     taken_q  [ROB_SIZE];

    logic [ROB_SIZE_WIDTH-1:0] head_q, tail_q;
    logic [ROB_SIZE_WIDTH-1:0] head_next, tail_next;
    logic [ROB_SIZE_WIDTH:0]   count_q, count_next;
    logic [ROB_SIZE_WIDTH-1:0] cdb_idx;

    logic do_alloc, do_cdb, do_commit;
    logic head_is_store, head_is_branch, mispredict;

    // Full is judged on the pre-commit count, so a full buffer cannot refill in its commit cycle.
    assign full_out    = (count_q == FULL_COUNT);
    assign new_tag_out = {1'b0, tail_q};
    assign cdb_idx     = cdb_tag[ROB_SIZE_WIDTH-1:0];

    assign do_alloc  = rdy_in && dec_valid && !full_out && !flush_out;
    assign do_cdb    = rdy_in && cdb_valid && !flush_out && (cdb_tag != NO_TAG)
                       && (state_q[cdb_idx] == ENTRY_ISSUED);
    assign do_commit = rdy_in && !flush_out && (state_q[head_q] == ENTRY_READY);

    assign head_is_store  = (type_q[head_q] == TYPE_STORE);
    assign head_is_branch = (type_q[head_q] == TYPE_BRANCH);
    assign mispredict     = do_commit && head_is_branch && (taken_q[head_q] != pred_q[head_q]);

    assign head_next = do_commit ? head_q + ROB_SIZE_WIDTH'(1) : head_q;
    assign tail_next = do_alloc  ? tail_q + ROB_SIZE_WIDTH'(1) : tail_q;

    always_comb begin
        count_next = count_q;
        case ({do_alloc, do_commit})
            2'b10:   count_next = count_q + (ROB_SIZE_WIDTH + 1)'(1);
            2'b01:   count_next = count_q - (ROB_SIZE_WIDTH + 1)'(1);
            default: count_next = count_q;
        endcase
    end

    // Per-entry lifecycle: EMPTY -> ISSUED -> READY -> EMPTY, wiped by a mispredict.
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) state_d[i] = state_q[i];
        if (do_cdb)    state_d[cdb_idx] = ENTRY_READY;
        if (do_alloc)  state_d[tail_q]  = ENTRY_ISSUED;
        if (do_commit) state_d[head_q]  = ENTRY_EMPTY;
        if (mispredict) begin
            for (int i = 0; i < ROB_SIZE; i++) state_d[i] = ENTRY_EMPTY;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) state_q[i] <= ENTRY_EMPTY;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) state_q[i] <= state_d[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i]   <= '0;
                rd_q[i]     <= '0;
                pred_q[i]   <= 1'b0;
                alt_pc_q[i] <= '0;
                value_q[i]  <= '0;
                taken_q[i]  <= 1'b0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_tag    <= NO_TAG;
            st_commit_out <= 1'b0;
            flush_out     <= 1'b0;
            flush_pc_out  <= '0;
        end else if (rdy_in) begin
            commit_valid  <= 1'b0;
            st_commit_out <= 1'b0;
            flush_out     <= 1'b0;
            if (do_cdb) begin
                value_q[cdb_idx] <= cdb_value;
                taken_q[cdb_idx] <= cdb_taken;
            end
            if (do_alloc) begin
                type_q[tail_q]   <= dec_type;
                rd_q[tail_q]     <= dec_rd;
                pred_q[tail_q]   <= dec_pred_taken;
                alt_pc_q[tail_q] <= dec_alt_pc;
            end
            if (do_commit) begin
                if (head_is_store) begin
                    st_commit_out <= 1'b1;
                end else if (head_is_branch) begin
                    if (mispredict) begin
                        flush_out    <= 1'b1;
                        flush_pc_out <= alt_pc_q[head_q];
                    end
                end else begin
                    commit_valid <= 1'b1;
                    commit_rd    <= rd_q[head_q];
                    commit_value <= value_q[head_q];
                    commit_tag   <= {1'b0, head_q};
                end
            end
            if (mispredict) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_next;
                tail_q  <= tail_next;
                count_q <= count_next;
            end
        end else begin
            commit_valid  <= 1'b0;
            st_commit_out <= 1'b0;
            flush_out     <= 1'b0;
        end
    end

    // Operand probes: a same-cycle CDB broadcast wins over the stored result.
    always_comb begin
        q1_ready = 1'b0;
        q1_value = '0;
        if (q1_tag == NO_TAG) begin
            q1_ready = 1'b1;
        end else if (cdb_valid && (cdb_tag == q1_tag)) begin
            q1_ready = 1'b1;
            q1_value = cdb_value;
        end else if (state_q[q1_tag[ROB_SIZE_WIDTH-1:0]] == ENTRY_READY) begin
            q1_ready = 1'b1;
            q1_value = value_q[q1_tag[ROB_SIZE_WIDTH-1:0]];
        end
    end

    always_comb begin
        q2_ready = 1'b0;
        q2_value = '0;
        if (q2_tag == NO_TAG) begin
            q2_ready = 1'b1;
        end else if (cdb_valid && (cdb_tag == q2_tag)) begin
            q2_ready = 1'b1;
            q2_value = cdb_value;
        end else if (state_q[q2_tag[ROB_SIZE_WIDTH-1:0]] == ENTRY_READY) begin
            q2_ready = 1'b1;
            q2_value = value_q[q2_tag[ROB_SIZE_WIDTH-1:0]];
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based model.
module tb_rob_commit_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        dec_valid;
    logic [1:0]  dec_type;
    logic [4:0]  dec_rd;
    logic        dec_pred_taken;
    logic [31:0] dec_alt_pc;
    logic [3:0]  new_tag_out;
    logic        full_out;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_tag;
    logic        st_commit_out;
    logic        flush_out;
    logic [31:0] flush_pc_out;

    rob_commit_unit #(.ROB_SIZE_WIDTH(3), .REG_NUM_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
        .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
        .new_tag_out(new_tag_out), .full_out(full_out),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag), .st_commit_out(st_commit_out),
        .flush_out(flush_out), .flush_pc_out(flush_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          tag;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        bit          ready;
        logic [31:0] value;
        logic        taken;
    } rob_entry_t;

    typedef struct {
        logic        dv;
        logic [1:0]  dt;
        logic [4:0]  rd;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic [3:0]  e_new_tag;
        logic        e_full;
        logic        e_cv;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic [3:0]  e_ctag;
    } vec_t;

    rob_entry_t  rob[$];
    int          m_tail;
    logic        e_cv, e_st, e_fl;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_fpc;
    logic [3:0]  e_tag;
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        rob.delete();
        m_tail = 0;
        e_cv = 0; e_st = 0; e_fl = 0;
        e_rd = 0; e_val = 0; e_tag = 4'hF; e_fpc = 0;
    endtask

    task automatic set_idle();
        rdy_in = 1'b1; dec_valid = 1'b0; dec_type = 2'd0; dec_rd = 5'd0;
        dec_pred_taken = 1'b0; dec_alt_pc = 32'h0;
        cdb_valid = 1'b0; cdb_tag = 4'hF; cdb_value = 32'h0; cdb_taken = 1'b0;
        q1_tag = 4'hF; q2_tag = 4'hF;
    endtask

    task automatic drive_alloc(input logic [1:0] t, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
        dec_valid = 1'b1; dec_type = t; dec_rd = rd; dec_pred_taken = pred; dec_alt_pc = alt;
    endtask

    task automatic drive_cdb(input logic [3:0] t, input logic [31:0] v, input logic tk);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk;
    endtask

    function automatic logic [3:0] pick_tag();
        int k;
        k = $urandom_range(0, 8);
        return (k == 8) ? 4'hF : 4'(k);
    endfunction

    task automatic model_query(input logic [3:0] t, output bit r, output logic [31:0] v);
        r = 0; v = 0;
        if (t == 4'hF) r = 1;
        else if (cdb_valid && cdb_tag == t) begin r = 1; v = cdb_value; end
        else foreach (rob[i]) if (rob[i].tag == int'(t) && rob[i].ready) begin r = 1; v = rob[i].value; end
    endtask

    task automatic check_reset(input string where);
        check_output({where, "_commit_valid"}, 32'(commit_valid), 32'h0);
        check_output({where, "_st_commit"},    32'(st_commit_out), 32'h0);
        check_output({where, "_flush"},        32'(flush_out), 32'h0);
        check_output({where, "_commit_rd"},    32'(commit_rd), 32'h0);
        check_output({where, "_commit_value"}, commit_value, 32'h0);
        check_output({where, "_commit_tag"},   32'(commit_tag), 32'hF);
        check_output({where, "_flush_pc"},     flush_pc_out, 32'h0);
        check_output({where, "_full"},         32'(full_out), 32'h0);
        check_output({where, "_new_tag"},      32'(new_tag_out), 32'h0);
    endtask

    // One clock of traffic: checks combinational outputs, advances the model, then checks registered outputs.
    task automatic apply_stimulus();
        bit          r;
        logic [31:0] v;
        bit          flushing;
        int          pre_size;
        bit          commit_now;
        rob_entry_t  h;
        rob_entry_t  n;
        #1;
        check_output("new_tag_out", 32'(new_tag_out), 32'(m_tail));
        check_output("full_out", 32'(full_out), 32'(rob.size() == 8));
        model_query(q1_tag, r, v);
        check_output("q1_ready", 32'(q1_ready), 32'(r));
        if (r) check_output("q1_value", q1_value, v);
        model_query(q2_tag, r, v);
        check_output("q2_ready", 32'(q2_ready), 32'(r));
        if (r) check_output("q2_value", q2_value, v);
        flushing = e_fl;
        e_cv = 0; e_st = 0; e_fl = 0;
        if (rdy_in) begin
            pre_size   = rob.size();
            commit_now = pre_size > 0 && rob[0].ready && !flushing;
            if (commit_now) h = rob.pop_front();
            if (cdb_valid && !flushing && cdb_tag != 4'hF)
                foreach (rob[i]) if (rob[i].tag == int'(cdb_tag[2:0]) && !rob[i].ready) begin
                    rob[i].ready = 1; rob[i].value = cdb_value; rob[i].taken = cdb_taken;
                end
            if (dec_valid && pre_size < 8 && !flushing) begin
                n.tag = m_tail; n.typ = dec_type; n.rd = dec_rd; n.pred = dec_pred_taken;
                n.alt = dec_alt_pc; n.ready = 0; n.value = 0; n.taken = 0;
                rob.push_back(n);
                m_tail = (m_tail + 1) % 8;
            end
            if (commit_now) begin
                if (h.typ == 2'd1) e_st = 1;
                else if (h.typ == 2'd2) begin
                    if (h.taken != h.pred) begin
                        e_fl = 1; e_fpc = h.alt; rob.delete(); m_tail = 0;
                    end
                end else begin
                    e_cv = 1; e_rd = h.rd; e_val = h.value; e_tag = 4'(h.tag);
                end
            end
        end
        @(posedge clk_in);
        #1;
        check_output("commit_valid", 32'(commit_valid), 32'(e_cv));
        check_output("commit_rd", 32'(commit_rd), 32'(e_rd));
        check_output("commit_value", commit_value, e_val);
        check_output("commit_tag", 32'(commit_tag), 32'(e_tag));
        check_output("st_commit_out", 32'(st_commit_out), 32'(e_st));
        check_output("flush_out", 32'(flush_out), 32'(e_fl));
        check_output("flush_pc_out", flush_pc_out, e_fpc);
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clk_in);
        rst_in = 1'b0;
        #2;
        check_reset("reset");
        rst_in = 1'b1;
        model_reset();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd0, 5'd5, 1'b0, 4'hF, 32'h0,  4'd0, 1'b0, 1'b0, 5'd0, 32'h0,  4'hF};
        vecs[1] = '{1'b1, 2'd0, 5'd6, 1'b0, 4'hF, 32'h0,  4'd1, 1'b0, 1'b0, 5'd0, 32'h0,  4'hF};
        vecs[2] = '{1'b1, 2'd0, 5'd7, 1'b0, 4'hF, 32'h0,  4'd2, 1'b0, 1'b0, 5'd0, 32'h0,  4'hF};
        vecs[3] = '{1'b0, 2'd0, 5'd0, 1'b1, 4'd1, 32'h22, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0,  4'hF};
        vecs[4] = '{1'b0, 2'd0, 5'd0, 1'b1, 4'd0, 32'h11, 4'd3, 1'b0, 1'b0, 5'd0, 32'h0,  4'hF};
        vecs[5] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'hF, 32'h0,  4'd3, 1'b0, 1'b1, 5'd5, 32'h11, 4'd0};
        vecs[6] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'hF, 32'h0,  4'd3, 1'b0, 1'b1, 5'd6, 32'h22, 4'd1};
        vecs[7] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'hF, 32'h0,  4'd3, 1'b0, 1'b0, 5'd6, 32'h22, 4'd1};

        rst_in = 1'b0;
        set_idle();
        model_reset();
        #12;
        check_reset("power_on");
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // In-order retirement with out-of-order completion.
        for (int i = 0; i < 8; i++) begin
            set_idle();
            dec_valid = vecs[i].dv; dec_type = vecs[i].dt; dec_rd = vecs[i].rd;
            cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_value = vecs[i].cval;
            #1;
            check_output($sformatf("vec%0d_new_tag", i), 32'(new_tag_out), 32'(vecs[i].e_new_tag));
            check_output($sformatf("vec%0d_full", i), 32'(full_out), 32'(vecs[i].e_full));
            apply_stimulus();
            check_output($sformatf("vec%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            check_output($sformatf("vec%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].e_rd));
            check_output($sformatf("vec%0d_commit_value", i), commit_value, vecs[i].e_val);
            check_output($sformatf("vec%0d_commit_tag", i), 32'(commit_tag), 32'(vecs[i].e_ctag));
        end
        set_idle();
        q1_tag = 4'd2;
        #1;
        check_output("tag2_still_held", 32'(q1_ready), 32'h0);
        apply_stimulus();

        // Fill to full, drop the ninth request, refuse allocation in the full-commit cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_idle();
            drive_alloc(2'd0, 5'(i + 1), 1'b0, 32'h0);
            apply_stimulus();
        end
        set_idle();
        drive_alloc(2'd0, 5'd9, 1'b0, 32'h0);
        #1;
        check_output("full_after_8", 32'(full_out), 32'h1);
        apply_stimulus();
        check_output("ninth_dropped_tail", 32'(new_tag_out), 32'h0);
        set_idle();
        drive_cdb(4'd0, 32'h55, 1'b0);
        apply_stimulus();
        set_idle();
        drive_alloc(2'd0, 5'd10, 1'b0, 32'h0);
        #1;
        check_output("full_precommit", 32'(full_out), 32'h1);
        apply_stimulus();
        check_output("commit_when_full", 32'(commit_valid), 32'h1);
        check_output("alloc_refused_tail", 32'(new_tag_out), 32'h0);
        check_output("not_full_after_commit", 32'(full_out), 32'h0);
        set_idle();
        drive_alloc(2'd0, 5'd10, 1'b0, 32'h0);
        apply_stimulus();
        check_output("refill_full", 32'(full_out), 32'h1);
        check_output("refill_tail", 32'(new_tag_out), 32'h1);

        // Mispredicted branch flushes younger completed entries.
        do_reset();
        set_idle(); drive_alloc(2'd2, 5'd0, 1'b0, 32'h1000); apply_stimulus();
        set_idle(); drive_alloc(2'd0, 5'd1, 1'b0, 32'h0);    apply_stimulus();
        set_idle(); drive_alloc(2'd0, 5'd2, 1'b0, 32'h0);    apply_stimulus();
        set_idle(); drive_cdb(4'd1, 32'hA1, 1'b0); apply_stimulus();
        set_idle(); drive_cdb(4'd2, 32'hA2, 1'b0); apply_stimulus();
        set_idle(); drive_cdb(4'd0, 32'h0, 1'b1);  apply_stimulus();
        set_idle(); apply_stimulus();
        check_output("flush_pulse", 32'(flush_out), 32'h1);
        check_output("flush_pc", flush_pc_out, 32'h1000);
        check_output("no_commit_on_flush", 32'(commit_valid), 32'h0);
        set_idle(); drive_alloc(2'd0, 5'd3, 1'b0, 32'h0); drive_cdb(4'd1, 32'hBB, 1'b0);
        apply_stimulus();
        check_output("flush_one_cycle", 32'(flush_out), 32'h0);
        check_output("no_younger_commit", 32'(commit_valid), 32'h0);
        check_output("alloc_ignored_in_flush", 32'(new_tag_out), 32'h0);
        set_idle(); drive_alloc(2'd0, 5'd4, 1'b0, 32'h0);
        #1;
        check_output("tag_after_flush", 32'(new_tag_out), 32'h0);
        apply_stimulus();

        // Query forwarding, then a rdy_in stall with a ready head.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle(); drive_alloc(2'd0, 5'(i + 1), 1'b0, 32'h0); apply_stimulus();
        end
        set_idle();
        q1_tag = 4'd3; q2_tag = 4'hF;
        drive_cdb(4'd3, 32'hABCD, 1'b0);
        #1;
        check_output("q1_cdb_ready", 32'(q1_ready), 32'h1);
        check_output("q1_cdb_value", q1_value, 32'hABCD);
        check_output("q2_notag_ready", 32'(q2_ready), 32'h1);
        check_output("q2_notag_value", q2_value, 32'h0);
        apply_stimulus();
        set_idle(); drive_cdb(4'd0, 32'h77, 1'b0); apply_stimulus();
        for (int k = 0; k < 4; k++) begin
            set_idle(); rdy_in = 1'b0; drive_alloc(2'd0, 5'd9, 1'b0, 32'h0);
            apply_stimulus();
            check_output("stall_no_commit", 32'(commit_valid), 32'h0);
            check_output("stall_tail_frozen", 32'(new_tag_out), 32'h4);
        end
        set_idle(); apply_stimulus();
        check_output("commit_after_stall", 32'(commit_valid), 32'h1);
        check_output("commit_after_stall_tag", 32'(commit_tag), 32'h0);

        // Asynchronous reset with five live entries.
        for (int i = 0; i < 3; i++) begin
            set_idle(); drive_alloc(2'd0, 5'(i + 20), 1'b0, 32'h0); apply_stimulus();
        end
        set_idle(); drive_cdb(4'd1, 32'h99, 1'b0); apply_stimulus();
        set_idle(); apply_stimulus();
        check_output("pre_reset_commit", 32'(commit_valid), 32'h1);
        #2;
        rst_in = 1'b0;
        #1;
        check_reset("async_reset");
        #1;
        rst_in = 1'b1;
        model_reset();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] tg;
            set_idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                drive_alloc(2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom), $urandom);
            if ($urandom_range(0, 9) < 6) begin
                if (rob.size() > 0 && $urandom_range(0, 3) != 0)
                    tg = 4'(rob[$urandom_range(0, rob.size() - 1)].tag);
                else
                    tg = pick_tag();
                drive_cdb(tg, $urandom, 1'($urandom));
            end
            q1_tag = pick_tag();
            q2_tag = pick_tag();
            apply_stimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
